// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-drive signals of the shared ALU arbiter
interface alu_arbiter_if #(
  parameter int P_WIDTH = 16
);
  logic               I_REQ_VALID_0;
  logic               I_REQ_VALID_1;
  logic               O_REQ_READY_0;
  logic               O_REQ_READY_1;
  logic [3:0]         I_REQ_OPCODE_0;
  logic [3:0]         I_REQ_OPCODE_1;
  logic [P_WIDTH-1:0] I_REQ_A_0;
  logic [P_WIDTH-1:0] I_REQ_A_1;
  logic [P_WIDTH-1:0] I_REQ_B_0;
  logic [P_WIDTH-1:0] I_REQ_B_1;
  logic               O_RSP_VALID;
  logic               I_RSP_READY;
  logic               O_RSP_ID;
  logic [P_WIDTH-1:0] O_RSP_C;
  logic [4:0]         O_RSP_STATUS;
  logic               O_ALU_ENABLE;
  logic [3:0]         O_ALU_OPCODE;
  logic [P_WIDTH-1:0] O_ALU_A;
  logic [P_WIDTH-1:0] O_ALU_B;
  logic [P_WIDTH-1:0] I_ALU_C;
  logic [4:0]         I_ALU_STATUS;
  modport slave (
    input  I_REQ_VALID_0, I_REQ_VALID_1, I_REQ_OPCODE_0, I_REQ_OPCODE_1,
    input  I_REQ_A_0, I_REQ_A_1, I_REQ_B_0, I_REQ_B_1, I_RSP_READY, I_ALU_C, I_ALU_STATUS,
    output O_REQ_READY_0, O_REQ_READY_1, O_RSP_VALID, O_RSP_ID, O_RSP_C, O_RSP_STATUS,
    output O_ALU_ENABLE, O_ALU_OPCODE, O_ALU_A, O_ALU_B
  );
  modport master (
    output I_REQ_VALID_0, I_REQ_VALID_1, I_REQ_OPCODE_0, I_REQ_OPCODE_1,
    output I_REQ_A_0, I_REQ_A_1, I_REQ_B_0, I_REQ_B_1, I_RSP_READY, I_ALU_C, I_ALU_STATUS,
    input  O_REQ_READY_0, O_REQ_READY_1, O_RSP_VALID, O_RSP_ID, O_RSP_C, O_RSP_STATUS,
    input  O_ALU_ENABLE, O_ALU_OPCODE, O_ALU_A, O_ALU_B
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port sequencer for the shared combinational ALU
module alu_arbiter #(
  parameter int P_WIDTH      = 16,
  parameter int P_MUL_CYCLES = 2
) (
  input logic           I_CLK,
  input logic           I_RESET,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [3:0] MUL_LOAD = 4'(P_MUL_CYCLES - 1);
  state_t             state_q;
  logic               last_q, id_q, gnt_d, acc_d, idle, issue;
  logic [3:0]         cnt_q, op_q, op_d;
  logic [P_WIDTH-1:0] a_q, b_q, c_q, a_d, b_d;
  logic [4:0]         st_q;
  assign idle  = state_q == IDLE;
  assign issue = state_q == ISSUE;
  assign gnt_d = (bus.I_REQ_VALID_0 && bus.I_REQ_VALID_1) ? ~last_q : bus.I_REQ_VALID_1;
  assign bus.O_REQ_READY_0 = idle && !I_RESET && bus.I_REQ_VALID_0 && !gnt_d;
  assign bus.O_REQ_READY_1 = idle && !I_RESET && bus.I_REQ_VALID_1 && gnt_d;
  assign acc_d = bus.O_REQ_READY_0 || bus.O_REQ_READY_1;
  assign op_d  = gnt_d ? bus.I_REQ_OPCODE_1 : bus.I_REQ_OPCODE_0;
  assign a_d   = gnt_d ? bus.I_REQ_A_1 : bus.I_REQ_A_0;
  assign b_d   = gnt_d ? bus.I_REQ_B_1 : bus.I_REQ_B_0;
  assign bus.O_ALU_ENABLE = issue;
  assign bus.O_ALU_OPCODE = issue ? op_q : '0;
  assign bus.O_ALU_A      = issue ? a_q : '0;
  assign bus.O_ALU_B      = issue ? b_q : '0;
  assign bus.O_RSP_VALID  = state_q == RESP;
  assign bus.O_RSP_ID     = id_q;
  assign bus.O_RSP_C      = c_q;
  assign bus.O_RSP_STATUS = st_q;
  // sequencer: accept a granted request, hold ISSUE for the op's cycle count, then hold the result until taken
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      st_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (acc_d) begin
          op_q    <= op_d;
          a_q     <= a_d;
          b_q     <= b_d;
          id_q    <= gnt_d;
          last_q  <= gnt_d;
          cnt_q   <= (op_d == 4'd6) ? MUL_LOAD : 4'd0;
          state_q <= ISSUE;
        end
        ISSUE: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          c_q     <= bus.I_ALU_C;
          st_q    <= bus.I_ALU_STATUS;
          state_q <= RESP;
        end
        RESP: if (bus.I_RSP_READY) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a small ALU stub
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [21:0] sb[$];
  logic acc_ids[$];
  logic [31:0] held_c, held_st, held_id;
  alu_arbiter_if #(.P_WIDTH(16)) bus ();
  alu_arbiter #(.P_WIDTH(16), .P_MUL_CYCLES(3)) dut (.I_CLK(clk), .I_RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  // ALU stub: {status,c}; ADD, SUBU (B-A) and MUL only, everything else returns zero
  function automatic logic [20:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] c;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[15:0];
        return {c[15], c == 16'd0, (a[15] == b[15]) && (c[15] != a[15]), 1'b0, s[16], c};
      end
      4'd5: begin
        c = b - a;
        return {1'b0, c == 16'd0, 1'b0, a > b, a > b, c};
      end
      4'd6: begin
        p = 32'(a) * 32'(b);
        c = p[15:0];
        return {1'b0, c == 16'd0, 3'b000, c};
      end
      default: return 21'd0;
    endcase
  endfunction
  logic [20:0] alu_out;
  always_comb begin
    alu_out = bus.O_ALU_ENABLE ? alu(bus.O_ALU_OPCODE, bus.O_ALU_A, bus.O_ALU_B) : 21'd0;
    bus.I_ALU_C = alu_out[15:0];
    bus.I_ALU_STATUS = alu_out[20:16];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [21:0] e;
    #1;
    if (bus.I_REQ_VALID_0 && bus.O_REQ_READY_0) begin
      sb.push_back({1'b0, alu(bus.I_REQ_OPCODE_0, bus.I_REQ_A_0, bus.I_REQ_B_0)});
      acc_ids.push_back(1'b0);
    end
    if (bus.I_REQ_VALID_1 && bus.O_REQ_READY_1) begin
      sb.push_back({1'b1, alu(bus.I_REQ_OPCODE_1, bus.I_REQ_A_1, bus.I_REQ_B_1)});
      acc_ids.push_back(1'b1);
    end
    if (bus.O_RSP_VALID && bus.I_RSP_READY) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_id", 32'(bus.O_RSP_ID), 32'(e[21]));
        chk("sb_c", 32'(bus.O_RSP_C), 32'(e[15:0]));
        chk("sb_st", 32'(bus.O_RSP_STATUS), 32'(e[20:16]));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic n, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (n) begin
      bus.I_REQ_VALID_1 = 1'b1; bus.I_REQ_OPCODE_1 = op; bus.I_REQ_A_1 = a; bus.I_REQ_B_1 = b;
    end else begin
      bus.I_REQ_VALID_0 = 1'b1; bus.I_REQ_OPCODE_0 = op; bus.I_REQ_A_0 = a; bus.I_REQ_B_0 = b;
    end
    #1;
  endtask
  task automatic drop();
    bus.I_REQ_VALID_0 = 1'b0;
    bus.I_REQ_VALID_1 = 1'b0;
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    bus.I_REQ_VALID_0 = 1'b1; bus.I_REQ_VALID_1 = 1'b1;
    bus.I_REQ_OPCODE_0 = '0; bus.I_REQ_OPCODE_1 = '0;
    bus.I_REQ_A_0 = '0; bus.I_REQ_A_1 = '0; bus.I_REQ_B_0 = '0; bus.I_REQ_B_1 = '0;
    bus.I_RSP_READY = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready0", 32'(bus.O_REQ_READY_0), 0);
    chk("rst_ready1", 32'(bus.O_REQ_READY_1), 0);
    chk("rst_rsp_valid", 32'(bus.O_RSP_VALID), 0);
    chk("rst_rsp", {11'd0, bus.O_RSP_ID, bus.O_RSP_STATUS, bus.O_RSP_C}, 0);
    chk("rst_alu", {bus.O_ALU_ENABLE, bus.O_ALU_OPCODE, bus.O_ALU_A[10:0], bus.O_ALU_B}, 0);
    drop();
    rst = 1'b0;
    // requester 0: ADD 0x7FFF + 1
    req(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    chk("add_ready0", 32'(bus.O_REQ_READY_0), 1);
    chk("add_ready1", 32'(bus.O_REQ_READY_1), 0);
    tick();
    drop();
    chk("add_c1_en", 32'(bus.O_ALU_ENABLE), 1);
    chk("add_c1_a", 32'(bus.O_ALU_A), 32'h7FFF);
    chk("add_c1_valid", 32'(bus.O_RSP_VALID), 0);
    tick();
    chk("add_c2_valid", 32'(bus.O_RSP_VALID), 1);
    chk("add_c2_en", 32'(bus.O_ALU_ENABLE), 0);
    chk("add_c", 32'(bus.O_RSP_C), 32'h8000);
    chk("add_st", 32'(bus.O_RSP_STATUS), 32'h14);
    chk("add_id", 32'(bus.O_RSP_ID), 0);
    tick();
    chk("add_c3_valid", 32'(bus.O_RSP_VALID), 0);
    // requester 1: SUBU
    req(1'b1, 4'd5, 16'h0005, 16'h0003);
    chk("subu_ready1", 32'(bus.O_REQ_READY_1), 1);
    tick();
    drop();
    tick();
    chk("subu_c", 32'(bus.O_RSP_C), 32'hFFFE);
    chk("subu_st", 32'(bus.O_RSP_STATUS), 32'h03);
    chk("subu_id", 32'(bus.O_RSP_ID), 1);
    tick();
    // MUL with three issue cycles
    req(1'b0, 4'd6, 16'h0003, 16'hFFFE);
    tick();
    drop();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mul_en_c%0d", i), 32'(bus.O_ALU_ENABLE), 1);
      chk($sformatf("mul_valid_c%0d", i), 32'(bus.O_RSP_VALID), 0);
      tick();
    end
    chk("mul_c4_valid", 32'(bus.O_RSP_VALID), 1);
    chk("mul_c", 32'(bus.O_RSP_C), 32'hFFFA);
    chk("mul_st", 32'(bus.O_RSP_STATUS), 32'h00);
    tick();
    // continuous contention after reset alternates 0,1,0,1
    pulse_reset();
    acc_ids.delete();
    req(1'b0, 4'd0, 16'h0100, 16'h0011);
    req(1'b1, 4'd5, 16'h0002, 16'h0040);
    for (int c = 0; c < 60 && acc_ids.size() < 4; c++) begin
      logic g0, g1;
      g0 = bus.O_REQ_READY_0;
      g1 = bus.O_REQ_READY_1;
      if (!bus.O_RSP_VALID && !bus.O_ALU_ENABLE)
        chk("fair_readies", {30'd0, g0, g1}, (acc_ids.size() % 2 == 0) ? 32'b10 : 32'b01);
      tick();
      if (g0) bus.I_REQ_A_0 = bus.I_REQ_A_0 + 16'd1;
      if (g1) bus.I_REQ_A_1 = bus.I_REQ_A_1 + 16'd1;
    end
    drop();
    chk("fair_count", 32'(acc_ids.size()), 4);
    for (int i = 0; i < acc_ids.size() && i < 4; i++)
      chk($sformatf("fair_id%0d", i), 32'(acc_ids[i]), 32'(i % 2));
    tick();
    tick();
    tick();
    chk("fair_drained", 32'(sb.size()), 0);
    // backpressure holds the response
    req(1'b0, 4'd0, 16'h0001, 16'h0002);
    tick();
    drop();
    tick();
    bus.I_RSP_READY = 1'b0;
    req(1'b1, 4'd5, 16'h0001, 16'h0009);
    held_c = 32'(bus.O_RSP_C);
    held_st = 32'(bus.O_RSP_STATUS);
    held_id = 32'(bus.O_RSP_ID);
    chk("bp_c_init", held_c, 32'h0003);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.O_RSP_VALID), 1);
      chk("bp_hold", {bus.O_RSP_ID, 10'd0, bus.O_RSP_STATUS, bus.O_RSP_C}, {held_id[0], 10'd0, held_st[4:0], held_c[15:0]});
      chk("bp_readies", {30'd0, bus.O_REQ_READY_0, bus.O_REQ_READY_1}, 0);
      tick();
    end
    bus.I_RSP_READY = 1'b1;
    tick();
    chk("bp_idle_valid", 32'(bus.O_RSP_VALID), 0);
    chk("bp_idle_ready1", 32'(bus.O_REQ_READY_1), 1);
    drop();
    chk("bp_drained", 32'(sb.size()), 0);
    // reset during MUL issue drops the operation
    req(1'b0, 4'd6, 16'h0007, 16'h0009);
    tick();
    drop();
    tick();
    chk("mr_in_issue", 32'(bus.O_ALU_ENABLE), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_en", 32'(bus.O_ALU_ENABLE), 0);
    chk("mr_async_alu", {bus.O_ALU_OPCODE, bus.O_ALU_A[11:0], bus.O_ALU_B}, 0);
    chk("mr_async_rsp", {10'd0, bus.O_RSP_VALID, bus.O_RSP_ID, bus.O_RSP_STATUS, bus.O_RSP_C}, 0);
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      chk("mr_no_rsp", 32'(bus.O_RSP_VALID), 0);
      tick();
    end
    req(1'b0, 4'd0, 16'h0010, 16'h0020);
    req(1'b1, 4'd0, 16'h0030, 16'h0040);
    chk("mr_grant", {30'd0, bus.O_REQ_READY_0, bus.O_REQ_READY_1}, 32'b10);
    tick();
    drop();
    tick();
    tick();
    chk("end_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-port arbiter for the shared CR16 combinational ALU. It accepts operation requests from two requesters, for example the instruction-execute path and a coprocessor or debug port, using valid/ready handshakes. Grants alternate round-robin when both requesters contend. The block registers the operands, drives the ALU for one cycle, or for `P_MUL_CYCLES` cycles on MUL, then holds the result and status flags until the consumer accepts them.

## Interface
Parameters:
- `P_WIDTH`, default 16: operand and result width; must match the ALU instance.
- `P_MUL_CYCLES`, default 2: number of ISSUE cycles for opcode 6 (MUL), a multicycle path; legal range 1..15.

Ports:
- `I_CLK`, in, 1: clock; all state changes on the rising edge.
- `I_RESET`, in, 1: reset, asynchronous and active-high.
- `I_REQ_VALID_0`, `I_REQ_VALID_1`, in, 1 each: request valid, per requester.
- `O_REQ_READY_0`, `O_REQ_READY_1`, out, 1 each: request accepted when valid and ready are both high at an edge.
- `I_REQ_OPCODE_0`, `I_REQ_OPCODE_1`, in, 4 each: ALU opcode.
- `I_REQ_A_0`, `I_REQ_A_1`, `I_REQ_B_0`, `I_REQ_B_1`, in, `P_WIDTH` each: operands.
- `O_RSP_VALID`, out, 1: response valid.
- `I_RSP_READY`, in, 1: consumer accepts the response.
- `O_RSP_ID`, out, 1: requester that owns the response.
- `O_RSP_C`, out, `P_WIDTH`: registered ALU result.
- `O_RSP_STATUS`, out, 5: registered ALU status {negative, zero, flag, low, carry}.
- `O_ALU_ENABLE`, out, 1: ALU enable.
- `O_ALU_OPCODE`, out, 4: ALU opcode.
- `O_ALU_A`, `O_ALU_B`, out, `P_WIDTH` each: ALU operands.
- `I_ALU_C`, in, `P_WIDTH`: ALU result.
- `I_ALU_STATUS`, in, 5: ALU status.

## Operation
- FSM states are IDLE, ISSUE and RESP. The reset state is IDLE.
- IDLE, grant selection:
  - Only one requester valid: that requester is granted.
  - Both valid: the grant goes to the requester that is not `last_grant`.
  - Only the granted requester sees its `O_REQ_READY_n` high, driven combinationally from state and grant. Both readies are low outside IDLE.
- Acceptance of a request:
  - Opcode, A and B are latched into internal registers.
  - `O_RSP_ID` and `last_grant` are set to the granted requester.
  - The cycle counter is loaded with `P_MUL_CYCLES-1` for opcode 6 and with 0 otherwise.
  - The FSM moves to ISSUE.
- ISSUE:
  - `O_ALU_ENABLE`=1; `O_ALU_OPCODE`, `O_ALU_A` and `O_ALU_B` come from the latched registers.
  - While the counter is non-zero it decrements and the FSM stays in ISSUE.
  - When the counter is zero, `I_ALU_C` and `I_ALU_STATUS` are captured into `O_RSP_C` and `O_RSP_STATUS`, and the FSM moves to RESP.
- Outside ISSUE: `O_ALU_ENABLE`=0 and `O_ALU_OPCODE`, `O_ALU_A`, `O_ALU_B` = 0.
- RESP:
  - `O_RSP_VALID`=1.
  - `O_RSP_ID`, `O_RSP_C` and `O_RSP_STATUS` stay stable until `I_RSP_READY`=1 at an edge, then the FSM goes to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Opcodes 15 and undefined: processed as single-cycle operations; the response carries whatever the ALU returns (C=0, status=0).
- Requests that are not granted are held off by their low ready signal. Requesters must hold valid and payload stable until accepted.

## Timing
- Reset values:
  - FSM state IDLE; `last_grant`=1, so requester 0 wins the first contention.
  - Counter 0.
  - `O_RSP_VALID`=0, `O_RSP_ID`=0, `O_RSP_C`=0, `O_RSP_STATUS`=0.
  - `O_ALU_ENABLE`=0 and all ALU drive outputs 0.
  - Both `O_REQ_READY` signals are 0 while `I_RESET` is high.
- Latency, with the accept edge at the end of cycle 0:
  - Non-MUL: ISSUE in cycle 1, `O_RSP_VALID` high from cycle 2.
  - MUL: ISSUE in cycles 1..`P_MUL_CYCLES`, `O_RSP_VALID` high from cycle `P_MUL_CYCLES`+1.
- Throughput:
  - Best case is one operation per 3 cycles (non-MUL, `I_RSP_READY` tied high).
  - Consumer backpressure holds RESP indefinitely.
- Reset asserted mid-operation: any in-flight request or pending response is dropped and all state returns to the reset values immediately. A requester that was already accepted sees no response.
- Fairness: under continuous contention the grants alternate 0,1,0,1.

## Test plan
- Requester 0 sends ADD (opcode 0), A=0x7FFF, B=0x0001, with `I_RSP_READY`=1 -> `O_RSP_VALID` in cycle 2 with C=0x8000, STATUS=0x14, ID=0.
- Requester 1 sends SUBU (opcode 5), A=0x0005, B=0x0003 -> C=0xFFFE, STATUS=0x03, ID=1.
- With `P_MUL_CYCLES`=3, MUL, A=0x0003, B=0xFFFE -> `O_ALU_ENABLE` high in cycles 1-3, `O_RSP_VALID` first high in cycle 4, C=0xFFFA, STATUS=0x00.
- Both requesters hold valid continuously for 4 operations after reset -> accepted IDs are 0,1,0,1, and the losing ready stays 0 during every IDLE cycle.
- `I_RSP_READY`=0 for 5 cycles in RESP -> `O_RSP_VALID`, C, STATUS and ID are held constant, both readies stay 0, then one cycle after ready the FSM is back in IDLE.
- `I_RESET` pulsed during ISSUE of a MUL -> all outputs return to 0 asynchronously, no response is produced, and the next contention after reset grants requester 0.
